lcd_line_arbiter: RTL and testbench
===================================

// Module: lcd_line_arbiter
// PURPOSE
//  Sequences the 4-bit character LCD engine (lcd) and shares it between two text requesters.
//  - At power-up, runs the engine's reset and clear commands.
//  - Afterwards, arbitrates round-robin between two clients, each of which writes one 16-char line.
//  - Replaces the fixed-string generator wherever more than one source needs the display.
//  - Sits between the client logic and the lcd engine; owns every engine command/ack handshake.
// PARAMETERS
//  TMO_W    20      width of the per-command watchdog counter
//  TIMEOUT  500000  cycles a command may stay asserted without its ack; must exceed the clear time (>=131072+128)
// PORTS
//  CCLK      in   1    system clock
//  reset_n   in   1    asynchronous, active-low reset
//  req       in   2    req[k]: client k requests a line write; level signal
//  line0     in   1    client 0 target row (0=top, DDRAM 0x00; 1=bottom, 0x40)
//  line1     in   1    client 1 target row
//  text0     in   128  client 0 characters; [127:120]=column 0 ... [7:0]=column 15
//  text1     in   128  client 1 characters, same layout
//  gnt       out  2    one-hot; high from grant until the end of that client's transfer
//  done      out  2    1-cycle pulse to the served client when its transfer ends (normal or abort)
//  ready     out  1    high while IDLE after the startup sequence has completed
//  err       out  1    sticky watchdog-timeout flag; cleared only by reset
//  initlcd   out  1    engine re-arm pulse
//  resetlcd  out  1    engine command level: power-on init
//  clearlcd  out  1    engine command level: clear display
//  addrlcd   out  1    engine command level: set DDRAM address
//  datalcd   out  1    engine command level: write character
//  lcddatin  out  8    engine operand (address or character)
//  lcdreset  in   1    ack for resetlcd
//  lcdclear  in   1    ack for clearlcd
//  lcdaddr   in   1    ack for addrlcd
//  lcddata   in   1    ack for datalcd
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs are 0, state=ST_ARM, rr_ptr=0, watchdog=0.
//  Command issue (common sub-sequence, "CMD(x)"):
//  - ARM: initlcd=1 for 1 cycle.
//  - GAP: initlcd=0 for 1 cycle.
//  - HOLD: command x=1 with lcddatin stable until the matching ack is sampled 1.
//  - The cycle the ack is seen, x drops to 0. No two command levels are ever high together.
//  Startup: CMD(resetlcd), then CMD(clearlcd), then IDLE with ready=1. req is ignored until ready.
//  IDLE arbitration, evaluated each cycle:
//  - Only one req high: that client wins.
//  - Both high: the client != rr_ptr wins. rr_ptr holds the last served client.
//  - The cycle after IDLE samples a winning req: gnt[k]=1, ready=0, and text/line are latched into a 128-bit shift register.
//  - Client inputs are don't-care after grant.
//  Transfer:
//  - CMD(addrlcd) with lcddatin = line ? 8'h40 : 8'h00.
//  - Then 16 x CMD(datalcd), lcddatin=shreg[127:120]; shreg shifts left by 8 after each data ack.
//  - A 4-bit char counter ends the transfer after column 15.
//  Completion:
//  - Cycle after the 16th ack: done[k]=1 for 1 cycle, gnt=0, rr_ptr=k, return to IDLE.
//  - ready=1 from the following cycle.
//  - req[k] still high at done re-arbitrates normally; the other requester wins if also pending.
//  - req dropping mid-transfer is ignored; the line is always completed.
//  Watchdog:
//  - Counter clears on entry to each HOLD and increments while HOLD waits.
//  - On reaching TIMEOUT: command level drops, err=1 (sticky).
//    - In a transfer: done[k] pulses, gnt=0, go to IDLE.
//    - In startup: go straight to IDLE with ready=1. The display is unusable, but clients are not deadlocked.
//  Ack already 1 on first HOLD cycle: accepted immediately (1-cycle HOLD).
//  Throughput: per command, ARM+GAP+HOLD = ack latency + 2 cycles. A line = 17 commands + 2 cycles arbitration/done.
// TESTING
//  (bench uses a behavioural engine model: ack rises N cycles after the command; ack clears on initlcd)
//  - Startup: N=5 -> resetlcd, then clearlcd, each preceded by an initlcd pulse; ready=1 after both; gnt=0 throughout.
//  - Single write: req=01, line0=1, text0="HELLO WORLD     " -> lcddatin=0x40 on addrlcd; then 0x48,0x45,0x4C...0x20 on 16 datalcd; done=01 once.
//  - Contention: req=11 held -> grant order 0,1,0,1; each done pulses exactly once per line.
//  - Timeout: TIMEOUT=64, model never acks datalcd on char 3 -> datalcd drops after 64 cycles; err=1, done pulse, ready=1; err stays 1.
//  - Reset mid-transfer: reset_n low at char 7 -> all outputs 0 immediately; startup re-runs, then serves pending req.
//  - Zero-latency ack (ack tied to command) -> each command takes 3 cycles; no command overlap; 16 chars in order.

Source files
------------

// File: rtl/lcd_line_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_line_arbiter
//
// Drives the 4-bit character LCD engine and shares it between two clients
// that each write one 16-character line.
//  - After reset, runs the engine's power-on init and clear commands, then
//    raises ready.
//  - In IDLE, picks a requesting client round-robin and latches its line
//    select and text.
//  - Issues one set-address command and then 16 write-character commands.
//  - Pulses done[k] to the client when its line has been written.
//
// Every engine command uses the same three phases:
//  - ARM: initlcd is pulsed for one cycle.
//  - GAP: one idle cycle.
//  - HOLD: the command level is held until its ack is sampled.
//
// A per-command watchdog aborts a HOLD that never sees its ack and sets a
// sticky err flag, so a dead display cannot deadlock the clients.
//
// Handshake: a command level (resetlcd/clearlcd/addrlcd/datalcd) is the
// request; the matching ack (lcdreset/lcdclear/lcdaddr/lcddata) is sampled on
// every rising CCLK edge while the level is high. The level and lcddatin stay
// stable until the cycle after the ack is sampled high. At most one level is
// ever high at a time.
//
// Ports
//  CCLK, reset_n         clock, asynchronous active-low reset
//  req[1:0]              level requests from client 0 / client 1
//  line0/1, text0/1      target row and 16 characters per client
//                        ([127:120] = column 0)
//  gnt[1:0]              one-hot, high for the whole transfer
//  done[1:0]             1-cycle end-of-transfer pulse (normal or abort)
//  ready                 high in IDLE once startup has finished
//  err                   sticky watchdog timeout flag
//  initlcd               engine re-arm pulse
//  resetlcd/clearlcd/
//  addrlcd/datalcd       engine command levels
//  lcddatin              engine operand
//  lcdreset/lcdclear/
//  lcdaddr/lcddata       engine acks
//  dbg_state_o           current FSM state, for observation only
// -----------------------------------------------------------------------------
module lcd_line_arbiter #(
    parameter int TMO_W   = 20,
    parameter int TIMEOUT = 500000
) (
    input  logic         CCLK,
    input  logic         reset_n,
    input  logic [1:0]   req,
    input  logic         line0,
    input  logic         line1,
    input  logic [127:0] text0,
    input  logic [127:0] text1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         ready,
    output logic         err,
    output logic         initlcd,
    output logic         resetlcd,
    output logic         clearlcd,
    output logic         addrlcd,
    output logic         datalcd,
    output logic [7:0]   lcddatin,
    input  logic         lcdreset,
    input  logic         lcdclear,
    input  logic         lcdaddr,
    input  logic         lcddata,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        ST_ARM  = 3'd0,
        ST_GAP  = 3'd1,
        ST_HOLD = 3'd2,
        ST_IDLE = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // The encoding doubles as the bit index into the command-level vector.
    typedef enum logic [1:0] {
        CMD_RST  = 2'd0,
        CMD_CLR  = 2'd1,
        CMD_ADDR = 2'd2,
        CMD_DATA = 2'd3
    } cmd_e;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    function automatic logic [1:0] onehot(input logic k);
        return k ? 2'b10 : 2'b01;
    endfunction

    state_e         state_q, state_d;
    cmd_e           cmd_q, cmd_d;
    logic           client_q, client_d;
    logic           rr_q, rr_d;
    logic [127:0]   shreg_q, shreg_d;
    logic           line_q, line_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;

    // All outputs are registered so that everything reads 0 during reset,
    // even though the reset state is ST_ARM.
    logic           initlcd_q, initlcd_d;
    logic [3:0]     lvl_q, lvl_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     done_q, done_d;
    logic           ready_q, ready_d;
    logic [7:0]     data_q, data_d;

    logic [3:0]     ack_vec;
    logic           ack;
    logic           win_vld;
    logic           win;
    logic           xfer_d;

    assign ack_vec = {lcddata, lcdaddr, lcdclear, lcdreset};
    assign ack     = ack_vec[cmd_q];

    // With both clients pending, the one that was not served last wins.
    assign win_vld = |req;
    assign win     = (req == 2'b11) ? ~rr_q : req[1];

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        client_d = client_q;
        rr_d     = rr_q;
        shreg_d  = shreg_q;
        line_d   = line_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        err_d    = err_q;

        case (state_q)
            // Coming out of reset initlcd_q is 0, so ARM lasts one extra
            // cycle to produce the pulse. On every later entry the pulse
            // is already high in the first ARM cycle.
            ST_ARM: begin
                if (initlcd_q) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_HOLD;
                wdog_d  = '0;
            end
            ST_HOLD: begin
                if (ack) begin
                    case (cmd_q)
                        CMD_RST: begin
                            cmd_d   = CMD_CLR;
                            state_d = ST_ARM;
                        end
                        CMD_CLR: begin
                            state_d = ST_IDLE;
                        end
                        CMD_ADDR: begin
                            cmd_d   = CMD_DATA;
                            state_d = ST_ARM;
                        end
                        default: begin
                            shreg_d = {shreg_q[119:0], 8'h00};
                            if (cnt_q == 4'd15) begin
                                state_d = ST_DONE;
                            end else begin
                                cnt_d   = cnt_q + 4'd1;
                                state_d = ST_ARM;
                            end
                        end
                    endcase
                end else if (wdog_q == TMO_LAST) begin
                    // Abort: a startup failure still releases the clients,
                    // and a transfer failure ends that client's line.
                    err_d   = 1'b1;
                    state_d = ((cmd_q == CMD_RST) || (cmd_q == CMD_CLR)) ? ST_IDLE : ST_DONE;
                end else begin
                    wdog_d = wdog_q + TMO_ONE;
                end
            end
            ST_IDLE: begin
                if (win_vld) begin
                    client_d = win;
                    shreg_d  = win ? text1 : text0;
                    line_d   = win ? line1 : line0;
                    cmd_d    = CMD_ADDR;
                    cnt_d    = 4'd0;
                    state_d  = ST_ARM;
                end
            end
            ST_DONE: begin
                rr_d    = client_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output values for the state being entered.
        xfer_d    = ((cmd_d == CMD_ADDR) || (cmd_d == CMD_DATA)) &&
                    ((state_d == ST_ARM) || (state_d == ST_GAP) || (state_d == ST_HOLD));
        initlcd_d = (state_d == ST_ARM);
        lvl_d     = (state_d == ST_HOLD) ? (4'b0001 << cmd_d) : 4'b0000;
        gnt_d     = xfer_d ? onehot(client_d) : 2'b00;
        done_d    = (state_d == ST_DONE) ? onehot(client_d) : 2'b00;
        ready_d   = (state_d == ST_IDLE);
        data_d    = 8'h00;
        if (state_d == ST_HOLD) begin
            if (cmd_d == CMD_ADDR) begin
                data_d = line_d ? 8'h40 : 8'h00;
            end else if (cmd_d == CMD_DATA) begin
                data_d = shreg_d[127:120];
            end
        end
    end

    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ARM;
            cmd_q     <= CMD_RST;
            client_q  <= 1'b0;
            rr_q      <= 1'b0;
            shreg_q   <= '0;
            line_q    <= 1'b0;
            cnt_q     <= 4'd0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            initlcd_q <= 1'b0;
            lvl_q     <= 4'b0000;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            ready_q   <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            client_q  <= client_d;
            rr_q      <= rr_d;
            shreg_q   <= shreg_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            initlcd_q <= initlcd_d;
            lvl_q     <= lvl_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign ready       = ready_q;
    assign err         = err_q;
    assign initlcd     = initlcd_q;
    assign resetlcd    = lvl_q[0];
    assign clearlcd    = lvl_q[1];
    assign addrlcd     = lvl_q[2];
    assign datalcd     = lvl_q[3];
    assign lcddatin    = data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_line_arbiter
//
// Bench for lcd_line_arbiter. A behavioural LCD engine acks each command
// after a fixed, random or zero latency. A reference model predicts, at each
// ready cycle, which client wins and the exact command stream for that line
// (row address, then the 16 characters) from the inputs the bench drives.
// A monitor compares every issued command, grant and done pulse against
// those predictions.
// -----------------------------------------------------------------------------
module tb_lcd_line_arbiter;

    localparam int TMO = 64;

    logic         CCLK = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic         line0 = 1'b0;
    logic         line1 = 1'b0;
    logic [127:0] text0 = '0;
    logic [127:0] text1 = '0;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         ready;
    logic         err;
    logic         initlcd;
    logic         resetlcd;
    logic         clearlcd;
    logic         addrlcd;
    logic         datalcd;
    logic [7:0]   lcddatin;
    logic         lcdreset;
    logic         lcdclear;
    logic         lcdaddr;
    logic         lcddata;
    logic [2:0]   dbg_state;

    lcd_line_arbiter #(.TMO_W(20), .TIMEOUT(TMO)) dut (
        .CCLK        (CCLK),
        .reset_n     (reset_n),
        .req         (req),
        .line0       (line0),
        .line1       (line1),
        .text0       (text0),
        .text1       (text1),
        .gnt         (gnt),
        .done        (done),
        .ready       (ready),
        .err         (err),
        .initlcd     (initlcd),
        .resetlcd    (resetlcd),
        .clearlcd    (clearlcd),
        .addrlcd     (addrlcd),
        .datalcd     (datalcd),
        .lcddatin    (lcddatin),
        .lcdreset    (lcdreset),
        .lcdclear    (lcdclear),
        .lcdaddr     (lcdaddr),
        .lcddata     (lcddata),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CCLK = ~CCLK;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, limit 900000 ns");
        $fatal(1, "global timeout");
    end

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // {cmd index[2:0], operand[7:0]}; cmd index = bit position in levels
    logic [10:0] exp_q[$];
    logic        exp_gnt_q[$];
    logic        gnt_log[$];
    int          done_cnt[2];
    int          exp_done[2];
    logic        rr_m = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_line(input logic [127:0] t, input logic ln, input int nchars);
        exp_q.push_back({3'd2, (ln ? 8'h40 : 8'h00)});
        for (int i = 0; i < nchars; i++) begin
            exp_q.push_back({3'd3, t[127 - 8 * i -: 8]});
        end
    endtask

    // ---------------- engine model ----------------
    logic [3:0] ack_q = 4'b0000;
    int         eng_cnt = 0;
    int         lat = 5;
    int         fixed_lat = 5;
    bit         rand_lat = 1'b0;
    bit         zero_lat = 1'b0;
    bit         stall_en = 1'b0;
    bit         stall_cmd = 1'b0;

    logic [3:0] levels;
    assign levels   = {datalcd, addrlcd, clearlcd, resetlcd};
    assign lcdreset = zero_lat ? resetlcd : ack_q[0];
    assign lcdclear = zero_lat ? clearlcd : ack_q[1];
    assign lcdaddr  = zero_lat ? addrlcd  : ack_q[2];
    assign lcddata  = zero_lat ? datalcd  : ack_q[3];

    logic [18:0] outs_vec;
    assign outs_vec = {gnt, done, ready, err, initlcd, resetlcd, clearlcd, addrlcd, datalcd, lcddatin};

    // ---------------- monitor + model, sampled on the falling edge ----------------
    logic [3:0] lvl_prev = 4'b0000;
    logic [1:0] done_prev = 2'b00;
    logic [1:0] gnt_prev = 2'b00;
    bit         armed = 1'b0;
    logic [7:0] held_op = 8'h00;
    bit         op_stable = 1'b1;
    int         hold_len = 0;
    int         arm_cyc = 0;
    int         data_idx = 0;
    logic       cur_w = 1'b0;
    bit         char7_hit = 1'b0;

    always @(negedge CCLK) begin : mon
        logic [3:0]  lv;
        logic [10:0] e;
        logic        w;
        if (!reset_n) begin
            ack_q     = 4'b0000;
            eng_cnt   = 0;
            lvl_prev  = 4'b0000;
            done_prev = 2'b00;
            gnt_prev  = 2'b00;
            armed     = 1'b0;
            data_idx  = 0;
            stall_cmd = 1'b0;
        end else begin
            lv = levels;
            arm_cyc++;

            // command ends
            if ((lvl_prev & ~lv) != 4'b0000) begin
                check_eq("op_stable", op_stable, 1);
                if (zero_lat) check_eq("zl_cycles", arm_cyc, 3);
                if (stall_cmd) check_eq("tmo_hold_len", hold_len, TMO);
                stall_cmd = 1'b0;
            end

            // command starts
            if ((lv & ~lvl_prev) != 4'b0000) begin
                check_eq("one_level", $countones(lv), 1);
                check_eq("armed_before_cmd", armed, 1);
                armed = 1'b0;
                if (exp_q.size() == 0) begin
                    check_eq("cmd_unexpected", lv, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("cmd_kind", lv, 4'b0001 << e[9:8]);
                    if (e[9:8] >= 2) check_eq("operand", lcddatin, e[7:0]);
                end
                if (lv[0] || lv[1]) begin
                    check_eq("startup_gnt", gnt, 0);
                    check_eq("startup_ready", ready, 0);
                end
                if (lv[2]) data_idx = 0;
                if (lv[3]) begin
                    if (data_idx == 7) char7_hit = 1'b1;
                    stall_cmd = stall_en && (data_idx == 3);
                    data_idx++;
                end
                held_op   = lcddatin;
                op_stable = 1'b1;
                hold_len  = 0;
            end
            if (lv != 4'b0000) begin
                if (lcddatin !== held_op) op_stable = 1'b0;
                hold_len++;
            end

            if (initlcd) begin
                armed   = 1'b1;
                arm_cyc = 0;
            end

            if (ready) check_eq("ready_gnt", gnt, 0);

            // grant starts
            if ((gnt != 2'b00) && (gnt_prev == 2'b00)) begin
                gnt_log.push_back(gnt[1]);
                if (exp_gnt_q.size() == 0) begin
                    check_eq("gnt_unexpected", gnt, 0);
                end else begin
                    cur_w = exp_gnt_q.pop_front();
                    check_eq("gnt", gnt, cur_w ? 2'b10 : 2'b01);
                end
            end

            // done pulse
            if (done != 2'b00) begin
                check_eq("done_width", done_prev, 0);
                check_eq("done", done, cur_w ? 2'b10 : 2'b01);
                check_eq("done_gnt", gnt, 0);
                check_eq("line_cmds_left", exp_q.size(), 0);
                done_cnt[cur_w]++;
            end

            // model: IDLE samples req at the coming edge
            if (ready && (req != 2'b00)) begin
                w    = (req == 2'b11) ? ~rr_m : req[1];
                rr_m = w;
                exp_gnt_q.push_back(w);
                exp_done[w]++;
                push_line(w ? text1 : text0, w ? line1 : line0, stall_en ? 4 : 16);
            end

            // engine: acks clear on initlcd, rise lat cycles after the command
            if (initlcd) begin
                ack_q   = 4'b0000;
                eng_cnt = 0;
                lat     = rand_lat ? $urandom_range(0, 6) : fixed_lat;
            end else if ((lv != 4'b0000) && ((ack_q & lv) == 4'b0000)) begin
                eng_cnt++;
                if ((eng_cnt >= lat) && !stall_cmd) ack_q = ack_q | lv;
            end

            gnt_prev  = gnt;
            done_prev = done;
            lvl_prev  = lv;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        exp_done[0] = 0;
        exp_done[1] = 0;
    endtask

    task automatic apply_reset();
        @(posedge CCLK);
        #2 reset_n = 1'b0;
        #1 check_eq("reset_outputs", outs_vec, 0);
        exp_q.delete();
        exp_gnt_q.delete();
        rr_m = 1'b0;
        clear_counts();
        repeat (3) @(posedge CCLK);
        exp_q.push_back({3'd0, 8'h00});
        exp_q.push_back({3'd1, 8'h00});
        #2 reset_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int i = 0;
        while (!ready && i < 3000) begin
            @(negedge CCLK);
            i++;
        end
        check_eq(tag, ready, 1);
    endtask

    task automatic wait_done(input int n, input string tag);
        int seen = 0;
        int i = 0;
        while (seen < n && i < 6000) begin
            @(negedge CCLK);
            i++;
            if (done != 2'b00) seen++;
        end
        check_eq(tag, seen, n);
    endtask

    task automatic drive_req(input logic [1:0] r);
        @(posedge CCLK);
        #2 req = r;
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] ord_exp[4] = '{2'd0, 2'd1, 2'd0, 2'd1};

    initial begin
        clear_counts();

        // startup
        apply_reset();
        wait_ready("startup_ready");
        check_eq("startup_err", err, 0);
        check_eq("startup_cmds_left", exp_q.size(), 0);

        // single write from client 0, bottom row
        line0 = 1'b1;
        text0 = "HELLO WORLD     ";
        drive_req(2'b01);
        wait_done(1, "single_done");
        req = 2'b00;
        wait_ready("single_ready");
        check_eq("single_cnt0", done_cnt[0], 1);

        // single write from client 1, top row
        line1 = 1'b0;
        text1 = {$urandom, $urandom, $urandom, $urandom};
        drive_req(2'b10);
        wait_done(1, "c1_done");
        req = 2'b00;
        wait_ready("c1_ready");

        // contention: both held, last served was client 1
        clear_counts();
        gnt_log.delete();
        line0 = 1'b0;
        line1 = 1'b1;
        drive_req(2'b11);
        wait_done(4, "cont_done");
        req = 2'b00;
        wait_ready("cont_ready");
        check_eq("cont_cnt0", done_cnt[0], 2);
        check_eq("cont_cnt1", done_cnt[1], 2);
        for (int i = 0; i < 4; i++) begin
            check_eq("cont_order", (gnt_log.size() > i) ? {1'b0, gnt_log[i]} : 2'd3, ord_exp[i]);
        end

        // zero-latency acks
        zero_lat = 1'b1;
        text0 = {$urandom, $urandom, $urandom, $urandom};
        line0 = 1'($urandom_range(0, 1));
        drive_req(2'b01);
        wait_done(1, "zl_done");
        req = 2'b00;
        wait_ready("zl_ready");
        zero_lat = 1'b0;

        // watchdog timeout on character 3
        stall_en = 1'b1;
        text0 = {$urandom, $urandom, $urandom, $urandom};
        drive_req(2'b01);
        wait_done(1, "tmo_done");
        req = 2'b00;
        check_eq("tmo_err", err, 1);
        wait_ready("tmo_ready");
        stall_en = 1'b0;

        // err stays set across a good transfer
        text1 = {$urandom, $urandom, $urandom, $urandom};
        drive_req(2'b10);
        wait_done(1, "sticky_done");
        req = 2'b00;
        wait_ready("sticky_ready");
        check_eq("err_sticky", err, 1);

        // randomized traffic with random latency, texts changing after grant
        clear_counts();
        rand_lat = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_req(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) text0 = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) text1 = {$urandom, $urandom, $urandom, $urandom};
            line0 = 1'($urandom_range(0, 1));
            line1 = 1'($urandom_range(0, 1));
            repeat ($urandom_range(5, 90)) @(posedge CCLK);
        end
        drive_req(2'b00);
        for (int i = 0; i < 1500; i++) begin
            @(negedge CCLK);
            if (ready && exp_q.size() == 0 && exp_gnt_q.size() == 0) break;
        end
        check_eq("rand_idle", ready, 1);
        check_eq("rand_gnt_left", exp_gnt_q.size(), 0);
        check_eq("rand_cnt0", done_cnt[0], exp_done[0]);
        check_eq("rand_cnt1", done_cnt[1], exp_done[1]);
        rand_lat = 1'b0;

        // reset in the middle of character 7, request left pending
        char7_hit = 1'b0;
        text1 = {$urandom, $urandom, $urandom, $urandom};
        drive_req(2'b10);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CCLK);
            if (char7_hit) break;
        end
        check_eq("char7_reached", char7_hit, 1);
        apply_reset();
        check_eq("reset_clears_err", err, 0);
        wait_done(1, "post_reset_done");
        req = 2'b00;
        wait_ready("post_reset_ready");
        check_eq("post_reset_cnt1", done_cnt[1], 1);
        check_eq("post_reset_err", err, 0);

        repeat (5) @(posedge CCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
